// File: rtl/freqdiv_meter.sv
// Period / high-time meter for a divided signal that is synchronous to clk_in.
// It recovers the division ratio, reports lock on repeated equal periods, and flags a sticky timeout.
module freqdiv_meter #(
    parameter int CNT_W  = 16,
    parameter int LOCK_N = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout,
    output logic             edge_pulse
);
    localparam int MW = (LOCK_N > 2) ? $clog2(LOCK_N) : 1;
    localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_N - 1);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t           state;
    logic             s_q;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] last_per;
    logic             last_ok;
    logic [MW-1:0]    match_cnt;
    logic [MW-1:0]    match_next;
    logic             rise;

    assign rise = sig_in & ~s_q;

    // Match counter saturates so lock holds through any run of equal periods.
    always_comb begin
        match_next = '0;
        if (last_ok && (per_cnt == last_per))
            match_next = (match_cnt == MATCH_MAX) ? MATCH_MAX : match_cnt + 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= IDLE;
            s_q        <= 1'b0;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            last_per   <= '0;
            last_ok    <= 1'b0;
            match_cnt  <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            s_q        <= sig_in;
            edge_pulse <= rise;
            meas_valid <= 1'b0;
            if (rise)
                timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (rise) begin
                        per_cnt <= CNT_W'(1);
                        hi_cnt  <= CNT_W'(1);
                        state   <= COUNT;
                    end
                end
                COUNT: begin
                    if (rise) begin
                        period     <= per_cnt;
                        high_time  <= hi_cnt;
                        meas_valid <= 1'b1;
                        per_cnt    <= CNT_W'(1);
                        hi_cnt     <= CNT_W'(1);
                        match_cnt  <= match_next;
                        locked     <= (match_next == MATCH_MAX);
                        last_per   <= per_cnt;
                        last_ok    <= 1'b1;
                    end else if (per_cnt == '1) begin
                        timeout   <= 1'b1;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        last_ok   <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        per_cnt <= per_cnt + 1'b1;
                        hi_cnt  <= hi_cnt + CNT_W'(sig_in);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_freqdiv_meter.sv
// Directed bench for freqdiv_meter with CNT_W=4 so the timeout boundary is reachable.
module tb_freqdiv_meter;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;
    logic             edge_pulse;

    int tests = 0;
    int failed = 0;

    freqdiv_meter #(.CNT_W(CNT_W), .LOCK_N(4)) dut (
        .clk_in    (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout),
        .edge_pulse(edge_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v);
        sig_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".period"}, 32'(period), 0);
        check({tag, ".high_time"}, 32'(high_time), 0);
        check({tag, ".meas_valid"}, 32'(meas_valid), 0);
        check({tag, ".locked"}, 32'(locked), 0);
        check({tag, ".timeout"}, 32'(timeout), 0);
        check({tag, ".edge_pulse"}, 32'(edge_pulse), 0);
    endtask

    // One period of h high and l low cycles; edge-time outputs describe the previous period.
    task automatic do_period(input int h, input int l, input logic mv, input int p,
                             input int hh, input logic lk, input string tag);
        int mv_cnt;
        int ep_cnt;
        step(1'b1);
        check({tag, ".edge_pulse"}, 32'(edge_pulse), 1);
        check({tag, ".meas_valid"}, 32'(meas_valid), 32'(mv));
        if (mv) begin
            check({tag, ".period"}, 32'(period), 32'(p));
            check({tag, ".high_time"}, 32'(high_time), 32'(hh));
        end
        check({tag, ".locked"}, 32'(locked), 32'(lk));
        check({tag, ".timeout"}, 32'(timeout), 0);
        mv_cnt = 0;
        ep_cnt = 0;
        for (int i = 0; i < h - 1; i++) begin
            step(1'b1);
            mv_cnt += int'(meas_valid);
            ep_cnt += int'(edge_pulse);
        end
        for (int i = 0; i < l; i++) begin
            step(1'b0);
            mv_cnt += int'(meas_valid);
            ep_cnt += int'(edge_pulse);
        end
        check({tag, ".quiet_mv"}, 32'(mv_cnt), 0);
        check({tag, ".quiet_ep"}, 32'(ep_cnt), 0);
    endtask

    initial begin
        int tcnt;
        // Reset state
        rst = 1'b1;
        step(1'b0);
        step(1'b0);
        check_zero("reset");
        rst = 1'b0;

        // DIV=4 (1100): first edge only starts counting, lock on 4th measurement
        do_period(2, 2, 1'b0, 0, 0, 1'b0, "div4_first");
        do_period(2, 2, 1'b1, 4, 2, 1'b0, "div4_m1");
        do_period(2, 2, 1'b1, 4, 2, 1'b0, "div4_m2");
        do_period(2, 2, 1'b1, 4, 2, 1'b0, "div4_m3");
        do_period(2, 2, 1'b1, 4, 2, 1'b1, "div4_m4");

        // DIV=5 (11000), then duty change to 11100 keeps lock
        do_period(2, 3, 1'b1, 4, 2, 1'b1, "div5_m0");
        do_period(2, 3, 1'b1, 5, 2, 1'b0, "div5_m1");
        do_period(2, 3, 1'b1, 5, 2, 1'b0, "div5_m2");
        do_period(2, 3, 1'b1, 5, 2, 1'b0, "div5_m3");
        do_period(3, 2, 1'b1, 5, 2, 1'b1, "div5_m4");
        do_period(2, 4, 1'b1, 5, 3, 1'b1, "duty_m5");

        // Period change to 6 drops lock, reasserts on 4th consecutive 6
        do_period(2, 4, 1'b1, 6, 2, 1'b0, "div6_m1");
        do_period(2, 4, 1'b1, 6, 2, 1'b0, "div6_m2");
        do_period(2, 4, 1'b1, 6, 2, 1'b0, "div6_m3");
        do_period(1, 1, 1'b1, 6, 2, 1'b1, "div6_m4");

        // Toggle every cycle
        do_period(1, 1, 1'b1, 2, 1, 1'b0, "tog_m1");
        do_period(1, 1, 1'b1, 2, 1, 1'b0, "tog_m2");
        do_period(1, 1, 1'b1, 2, 1, 1'b0, "tog_m3");

        // Timeout: one edge then held low, fires exactly 15 cycles later
        step(1'b1);
        check("to_edge.meas_valid", 32'(meas_valid), 1);
        check("to_edge.period", 32'(period), 2);
        check("to_edge.locked", 32'(locked), 1);
        tcnt = 0;
        for (int i = 0; i < 14; i++) begin
            step(1'b0);
            tcnt += int'(timeout);
        end
        check("to_early", 32'(tcnt), 0);
        step(1'b0);
        check("to_fire.timeout", 32'(timeout), 1);
        check("to_fire.locked", 32'(locked), 0);
        step(1'b0);
        check("to_sticky", 32'(timeout), 1);

        // Recovery: next edge clears timeout without a measurement
        step(1'b1);
        check("rec_edge.timeout", 32'(timeout), 0);
        check("rec_edge.edge_pulse", 32'(edge_pulse), 1);
        check("rec_edge.meas_valid", 32'(meas_valid), 0);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        // Edge lands exactly at max count: period 15, no timeout
        do_period(1, 14, 1'b1, 4, 1, 1'b0, "rec_meas");
        do_period(2, 2, 1'b1, 15, 1, 1'b0, "max_per");
        check("max_per.no_timeout", 32'(timeout), 0);

        do_period(2, 2, 1'b1, 4, 2, 1'b0, "relock_m1");
        do_period(2, 2, 1'b1, 4, 2, 1'b0, "relock_m2");
        do_period(2, 2, 1'b1, 4, 2, 1'b0, "relock_m3");
        do_period(2, 2, 1'b1, 4, 2, 1'b1, "relock_m4");

        // Reset mid-period while locked
        step(1'b1);
        check("pre_rst.locked", 32'(locked), 1);
        step(1'b1);
        rst = 1'b1;
        step(1'b0);
        check_zero("mid_rst");
        rst = 1'b0;
        do_period(2, 2, 1'b0, 0, 0, 1'b0, "post_rst_first");
        do_period(2, 2, 1'b1, 4, 2, 1'b0, "post_rst_m1");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
